pll_reset_seq: RTL

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq_pkg.sv | 28 ++
 rtl/pll_reset_seq_sync_2ff.sv | 31 +++
 rtl/pll_reset_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pll_reset_seq_pkg.sv
// ============================================================
// pll_reset_seq_pkg : state encoding and default timing constants for pll_reset_seq
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_DDR_INIT  = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYCLES       = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES  = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES   = 1024;
  localparam int DEF_CALIB_TIMEOUT_CYCLES = 1048576;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_seq_sync_2ff.sv
// ============================================================
// sync_2ff : 1-bit two-flop synchronizer, synchronous active-low reset
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// ============================================================
// pll_reset_seq : PLL / DDR3 / core reset sequencer with lock and calibration watchdogs
// Build option  : define PLL_RESET_SEQ_STATS_EN to add the lock_loss_cnt output
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES       = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES  = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES   = DEF_LOCK_STABLE_CYCLES,
  parameter int CALIB_TIMEOUT_CYCLES = DEF_CALIB_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       calib_done,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       ddr_rstn,
  output logic       sys_rstn,
  output logic [2:0] state,
`ifdef PLL_RESET_SEQ_STATS_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic       seq_ready
);

  localparam int c_max_cycles = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                       max_of(LOCK_STABLE_CYCLES, CALIB_TIMEOUT_CYCLES));
  localparam int c_cnt_w      = $clog2(c_max_cycles) + 1;

  localparam logic [c_cnt_w-1:0] c_pll_last   = c_cnt_w'(PLL_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_lock_last  = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_calib_last = c_cnt_w'(CALIB_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock_s=1 is the first of the stable run,
  // so STABLE itself only needs to observe the remaining cycles.
  localparam logic [c_cnt_w-1:0] c_stable_last =
    c_cnt_w'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic w_lock_s;
  logic w_calib_s;

  sync_2ff u_sync_lock (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (pll_lock),
    .o_q    (w_lock_s)
  );

  sync_2ff u_sync_calib (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (calib_done),
    .o_q    (w_calib_s)
  );

  state_e             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pll_reset;
  logic               r_ddr_rstn;
  logic               r_sys_rstn;
  logic               r_seq_ready;

  state_e w_next;
  logic   w_enter;

  always_comb begin
    w_next = r_state;
    if (relock_req) begin
      w_next = ST_PLL_RST;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == c_pll_last) w_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s)                 w_next = ST_STABLE;
          else if (r_cnt == c_lock_last) w_next = ST_PLL_RST;
        end
        ST_STABLE: begin
          if (!w_lock_s)                   w_next = ST_WAIT_LOCK;
          else if (r_cnt == c_stable_last) w_next = ST_DDR_INIT;
        end
        ST_DDR_INIT: begin
          if (!w_lock_s)                  w_next = ST_PLL_RST;
          else if (r_cnt == c_calib_last) w_next = ST_PLL_RST;
          else if (w_calib_s)             w_next = ST_RUN;
        end
        ST_RUN: begin
          if (!w_lock_s) w_next = ST_PLL_RST;
        end
        default: w_next = ST_PLL_RST;
      endcase
    end
  end

  // A relock request re-enters PLL_RST from PLL_RST and must still restart the count.
  assign w_enter = relock_req || (w_next != r_state);

  // Outputs are decoded from the next state so they change on the same edge as r_state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_pll_reset <= 1'b1;
      r_ddr_rstn  <= 1'b0;
      r_sys_rstn  <= 1'b0;
      r_seq_ready <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_enter ? '0 : ((r_cnt != '1) ? r_cnt + c_cnt_one : r_cnt);
      r_pll_reset <= (w_next == ST_PLL_RST);
      r_ddr_rstn  <= (w_next == ST_DDR_INIT) || (w_next == ST_RUN);
      r_sys_rstn  <= (w_next == ST_RUN);
      r_seq_ready <= (w_next == ST_RUN);
    end
  end

  assign pll_reset = r_pll_reset;
  assign ddr_rstn  = r_ddr_rstn;
  assign sys_rstn  = r_sys_rstn;
  assign seq_ready = r_seq_ready;
  assign state     = r_state;

`ifdef PLL_RESET_SEQ_STATS_EN
  logic       w_loss_evt;
  logic [7:0] r_loss_cnt;

  assign w_loss_evt = !relock_req && !w_lock_s &&
                      ((r_state == ST_DDR_INIT) || (r_state == ST_RUN) ||
                       ((r_state == ST_WAIT_LOCK) && (r_cnt == c_lock_last)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

`default_nettype wire
